// File: rtl/imem_responder_pkg.sv
// Shared fetch-side types: responder FSM states, cache line geometry and the reset PC.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } imem_state_t;

    localparam int LINE_BYTES = 32;
    localparam int BEATS      = 4;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int BEAT_BITS  = LINE_BITS / BEATS;

    // First instruction fetched after reset; fetch uses the same constant.
    localparam logic [31:0] RESET_PC = 32'h6000_0000;

    // Pick 32-bit word 'sel' (address bits [4:2]) out of a full line.
    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [2:0]           sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side read port plus burst memory port of the instruction responder.
interface imem_responder_if;

    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;

    logic [31:0] dfp_addr;
    logic        dfp_read;
    logic [63:0] dfp_rdata;
    logic        dfp_rvalid;

    // The responder itself.
    modport slave (
        input  ufp_addr, ufp_rmask, dfp_rdata, dfp_rvalid,
        output ufp_rdata, ufp_resp, dfp_addr, dfp_read
    );

    // The surrounding fetch stage and memory adapter.
    modport master (
        output ufp_addr, ufp_rmask, dfp_rdata, dfp_rvalid,
        input  ufp_rdata, ufp_resp, dfp_addr, dfp_read
    );

endinterface

// File: rtl/imem_line_array.sv
// Direct-mapped line store: valid/tag/data flops, one combinational read port
// and one full-line write port. Only the valid bits are reset.
module imem_line_array
    import rv32i_types::*;
#(
    parameter int SETS = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(SETS)-1:0]             rd_idx,
    output logic                                rd_valid,
    output logic [32-5-$clog2(SETS)-1:0]        rd_tag,
    output logic [LINE_BITS-1:0]                rd_line,
    input  logic                                wr_en,
    input  logic [$clog2(SETS)-1:0]             wr_idx,
    input  logic [32-5-$clog2(SETS)-1:0]        wr_tag,
    input  logic [LINE_BITS-1:0]                wr_line
);

    localparam int TAG_W = 32 - 5 - $clog2(SETS);

    logic [SETS-1:0]      valid;
    logic [TAG_W-1:0]     tags  [SETS];
    logic [LINE_BITS-1:0] lines [SETS];

    // Valid bits: cleared by reset (which wins over a same-cycle fill), set by a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and line storage: plain data, written whole on a completed fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = lines[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-side memory responder: direct-mapped read-only line store in
// front of a 4-beat burst port. Hits answer next cycle; misses fetch a line.
module imem_responder
    import rv32i_types::*;
#(
    parameter int SETS = 16
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 5 - IDX_W;
    localparam int IDX_LO = 5;
    localparam int IDX_HI = 5 + IDX_W - 1;
    localparam int TAG_LO = 5 + IDX_W;

    imem_state_t          state;
    imem_state_t          state_next;

    logic [31:2]          addr_q;
    logic [1:0]           beat_cnt;
    logic [LINE_BITS-1:0] line_buf;
    logic [LINE_BITS-1:0] fill_line;

    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 wr_en;
    logic                 req_seen;
    logic                 hit;
    logic                 last_beat;

    // Byte-offset bits of the fetch address carry no information for word reads.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^bus.ufp_addr[1:0];

    assign req_seen  = (bus.ufp_rmask != 4'b0000);
    assign last_beat = (state == FILL) && bus.dfp_rvalid && (beat_cnt == 2'(BEATS - 1));

    // In IDLE the lookup uses the live fetch address so a hit costs no extra
    // cycle; afterwards the latched address owns the read port.
    assign rd_idx = (state == IDLE) ? bus.ufp_addr[IDX_HI:IDX_LO] : addr_q[IDX_HI:IDX_LO];
    assign hit    = rd_valid && (rd_tag == bus.ufp_addr[31:TAG_LO]);

    // The final beat is merged here so the array can be written in the same
    // cycle it arrives, letting the response follow immediately.
    always_comb begin
        fill_line = line_buf;
        fill_line[{beat_cnt, 6'b0} +: BEAT_BITS] = bus.dfp_rdata;
    end

    assign wr_en = last_beat;

    imem_line_array #(
        .SETS (SETS)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (addr_q[IDX_HI:IDX_LO]),
        .wr_tag   (addr_q[31:TAG_LO]),
        .wr_line  (fill_line)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all externally visible outputs.
    always_comb begin
        state_next    = state;
        bus.ufp_resp  = 1'b0;
        bus.ufp_rdata = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_addr  = '0;
        unique case (state)
            IDLE: begin
                if (req_seen) begin
                    state_next = hit ? RESP : REQ;
                end
            end
            REQ: begin
                bus.dfp_read = 1'b1;
                bus.dfp_addr = {addr_q[31:5], 5'b0};
                state_next   = FILL;
            end
            FILL: begin
                if (last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.ufp_resp  = 1'b1;
                bus.ufp_rdata = line_word(rd_line, addr_q[4:2]);
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address latch: captured once per request; later address changes are ignored.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_seen) begin
            addr_q <= bus.ufp_addr[31:2];
        end
    end

    // Beat counter: cleared while issuing the burst, advanced per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == REQ) begin
            beat_cnt <= '0;
        end else if ((state == FILL) && bus.dfp_rvalid) begin
            beat_cnt <= beat_cnt + 2'd1;
        end
    end

    // Line buffer: collects beats in ascending order during a fill.
    always_ff @(posedge clk) begin
        if ((state == FILL) && bus.dfp_rvalid) begin
            line_buf <= fill_line;
        end
    end

endmodule
